// File: rtl/alu_op_sequencer.sv
// Micro-instruction sequencer for the 8-bit PowerALU: holds a small program
// and issues one opcode/operand pair per clock with repeat, halt and abort.
module alu_op_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [DATA_W+7:0]   prog_wdata,
  output logic [3:0]          opcode,
  output logic [DATA_W-1:0]   a,
  output logic                alu_valid,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   pc
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [DATA_W+7:0] HALT_WORD = {OP_HALT, 4'h0, {DATA_W{1'b0}}};

  // Handshake: alu_valid is a one-cycle qualifier with no back-pressure; the
  // ALU consumes opcode/a in every cycle where alu_valid is high.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W+7:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DATA_W+7:0]   cur_word;
  logic [3:0]          cur_op;
  logic [3:0]          cur_rpt;
  logic [DATA_W-1:0]   cur_operand;
  logic                mem_we;

  assign cur_word    = mem_q[pc_q];
  assign cur_op      = cur_word[DATA_W+7:DATA_W+4];
  assign cur_rpt     = cur_word[DATA_W+3:DATA_W];
  assign cur_operand = cur_word[DATA_W-1:0];
  assign mem_we      = (state_q == S_IDLE) && prog_we;

  // Program store; reset fills every word with HALT so an unloaded program stops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= HALT_WORD;
      end
    end else if (mem_we) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      opcode_q <= '0;
      a_q      <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cur_op[3:2] == 2'b00) begin
          opcode_d = cur_op;
          a_d      = cur_operand;
          valid_d  = 1'b1;
          // cnt_q counts issues already made of this word; the last one advances pc.
          if (cnt_q == cur_rpt) begin
            pc_d  = pc_q + ADDR_W'(1);
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (cur_op == OP_HALT) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          pc_d  = pc_q + ADDR_W'(1);
          cnt_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign opcode    = opcode_q;
  assign a         = a_q;
  assign alu_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus random programs, each
// program expanded by a reference model into an expected per-cycle trace.
module tb_alu_op_sequencer;

  localparam int W = 19;  // {valid, done, busy, pc[3:0], op[3:0], a[7:0]}
  localparam logic [15:0] HALT_W = 16'hF000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic [3:0]  opcode;
  logic [7:0]  a;
  logic        alu_valid, busy, done;
  logic [3:0]  pc;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0]  prog_m [16];
  logic [3:0]   m_op;
  logic [7:0]   m_a;
  logic [3:0]   m_pc;
  logic [W-1:0] exp_q [$];

  alu_op_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .opcode(opcode), .a(a),
    .alu_valid(alu_valid), .busy(busy), .done(done), .pc(pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input int op, input int rpt, input int opd);
    logic [3:0] o4, r4;
    logic [7:0] d8;
    o4 = 4'(op);
    r4 = 4'(rpt);
    d8 = 8'(opd);
    return {o4, r4, d8};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) prog_m[i] = HALT_W;
    m_op = 4'h0;
    m_a  = 8'h00;
    m_pc = 4'h0;
  endtask

  // Expand the stored program into the per-cycle outputs expected after each edge.
  function automatic void build_trace(input int max, output bit halted);
    logic [3:0]  p, op, rpt;
    logic [7:0]  opd;
    logic [15:0] w;
    p = 4'h0;
    halted = 1'b0;
    exp_q.delete();
    while (exp_q.size() < max && !halted) begin
      w   = prog_m[p];
      op  = w[15:12];
      rpt = w[11:8];
      opd = w[7:0];
      if (op <= 4'd3) begin
        for (int k = 0; k <= int'(rpt) && exp_q.size() < max; k++) begin
          m_op = op;
          m_a  = opd;
          if (k == int'(rpt)) p = p + 4'd1;
          exp_q.push_back({1'b1, 1'b0, 1'b1, p, op, opd});
        end
      end else if (op == 4'hF) begin
        exp_q.push_back({1'b0, 1'b1, 1'b0, p, m_op, m_a});
        halted = 1'b1;
      end else begin
        p = p + 4'd1;
        exp_q.push_back({1'b0, 1'b0, 1'b1, p, m_op, m_a});
      end
      m_pc = p;
    end
  endfunction

  // driver tasks
  task automatic write_word(input logic [3:0] addr, input logic [15:0] word);
    prog_we    = 1'b1;
    prog_addr  = addr;
    prog_wdata = word;
    tick();
    prog_we    = 1'b0;
    prog_m[addr] = word;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_start_busy"}, 32'(busy), 32'd1);
    chk({tag, "_start_valid"}, 32'(alu_valid), 32'd0);
    chk({tag, "_start_pc"}, 32'(pc), 32'd0);
  endtask

  task automatic check_entry(input string tag, input logic [W-1:0] e);
    chk({tag, "_valid"}, 32'(alu_valid), 32'(e[18]));
    chk({tag, "_done"},  32'(done),      32'(e[17]));
    chk({tag, "_busy"},  32'(busy),      32'(e[16]));
    chk({tag, "_pc"},    32'(pc),        32'(e[15:12]));
    chk({tag, "_op"},    32'(opcode),    32'(e[11:8]));
    chk({tag, "_a"},     32'(a),         32'(e[7:0]));
  endtask

  // Run a trace; noisy drives start and a write to word 5 throughout (both must be ignored).
  task automatic run_trace(input string tag, input int max, input bit noisy, output bit halted);
    logic [W-1:0] e;
    build_trace(max, halted);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (noisy) begin
        prog_we    = 1'b1;
        prog_addr  = 4'd5;
        prog_wdata = mk(0, 0, 99);
        start      = 1'b1;
      end
      tick();
      check_entry(tag, e);
    end
    prog_we = 1'b0;
    start   = 1'b0;
  endtask

  task automatic after_halt(input string tag);
    tick();
    check_entry({tag, "_idle"}, {1'b0, 1'b0, 1'b0, m_pc, m_op, m_a});
  endtask

  task automatic do_abort(input string tag);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk({tag, "_ab_valid"}, 32'(alu_valid), 32'd0);
    chk({tag, "_ab_busy"},  32'(busy),      32'd0);
    chk({tag, "_ab_done"},  32'(done),      32'd0);
    chk({tag, "_ab_op"},    32'(opcode),    32'(m_op));
    chk({tag, "_ab_a"},     32'(a),         32'(m_a));
    tick();
    chk({tag, "_ab_done2"}, 32'(done),      32'd0);
    chk({tag, "_ab_busy2"}, 32'(busy),      32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_op"},    32'(opcode),    32'd0);
    chk({tag, "_a"},     32'(a),         32'd0);
    chk({tag, "_valid"}, 32'(alu_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
    chk({tag, "_pc"},    32'(pc),        32'd0);
  endtask

  initial begin
    bit halted;
    int max;
    int r;
    logic [15:0] w;

    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_wdata = '0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // empty program halts immediately
    do_start("empty");
    run_trace("empty", 8, 1'b0, halted);
    chk("empty_halted", 32'(halted), 32'd1);
    after_halt("empty");

    // basic chained program with repeat
    write_word(4'd0, mk(0, 0, 10));
    write_word(4'd1, mk(1, 2, -15));
    write_word(4'd2, mk(2, 0, 20));
    write_word(4'd3, HALT_W);
    do_start("basic");
    run_trace("basic", 10, 1'b0, halted);
    after_halt("basic");

    // reserved opcode consumes one silent cycle
    write_word(4'd0, mk(0, 0, 127));
    write_word(4'd1, mk(7, 0, 0));
    write_word(4'd2, mk(3, 0, -5));
    do_start("resv");
    run_trace("resv", 10, 1'b0, halted);
    after_halt("resv");

    // abort in IDLE blocks a coincident start
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);

    // abort on 4th issue of a long repeat, then a full restart
    write_word(4'd0, mk(1, 15, 1));
    write_word(4'd1, HALT_W);
    do_start("abrt");
    run_trace("abrt", 4, 1'b0, halted);
    do_abort("abrt");
    do_start("rerun");
    run_trace("rerun", 40, 1'b0, halted);
    chk("rerun_halted", 32'(halted), 32'd1);
    after_halt("rerun");

    // start coincident with a write: write lands and start is honoured
    prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = mk(2, 1, 33);
    prog_m[0] = mk(2, 1, 33);
    do_start("wrstart");
    prog_we = 1'b0;
    run_trace("wrstart", 10, 1'b0, halted);
    after_halt("wrstart");

    // wrap with no HALT; writes and start during RUN are ignored
    for (int i = 0; i < 16; i++) write_word(4'(i), mk(0, 0, i));
    do_start("wrap");
    run_trace("wrap", 22, 1'b1, halted);
    do_abort("wrap");

    // random programs
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 9);
        if (r < 7)       w = mk(r % 4, $urandom_range(0, 3), $urandom_range(0, 255));
        else if (r == 7) w = mk($urandom_range(4, 14), $urandom_range(0, 15), $urandom_range(0, 255));
        else             w = HALT_W;
        write_word(4'(i), w);
      end
      max = $urandom_range(5, 50);
      do_start("rnd");
      run_trace("rnd", max, 1'b0, halted);
      if (halted) after_halt("rnd");
      else do_abort("rnd");
    end

    // asynchronous reset between edges in the middle of a run
    write_word(4'd0, mk(1, 15, 7));
    do_start("arst");
    run_trace("arst", 3, 1'b0, halted);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    #1;
    rst = 1'b0;
    model_reset();
    tick();
    check_reset_outputs("arst_post");
    do_start("arst_mem");
    run_trace("arst_mem", 8, 1'b0, halted);
    chk("arst_mem_halted", 32'(halted), 32'd1);
    after_halt("arst_mem");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
